// File: rtl/egress_rr_arbiter_pkg.sv
// egress_rr_arbiter_pkg
//   Shared definitions for the egress round-robin arbiter:
//   - FSM state encoding (IDLE / ACTIVE / DRAIN)
//   - destination codes carried on dest_out and held in the arbiter pointer
//   - pop-to-valid latency of the merge pipeline
package egress_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } arb_state_e;

   localparam logic DEST_D0 = 1'b0;
   localparam logic DEST_D1 = 1'b1;

   localparam int unsigned POP_LATENCY = 2;

endpackage

// File: rtl/egress_rr_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin grant with a registered last-served pointer.
//   Ports:
//     clk    - clock
//     reset  - synchronous active-high reset; pointer set so req[0] wins first
//     req    - request vector, bit x = source x has data
//     enable - when low no grant is issued and the pointer holds
//     grant  - one-hot grant (combinational), 2'b00 when nothing granted
module rr_arb2
   import egress_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic last_q;
   logic last_d;

   // Grant selection: a lone requester always wins, on contention the
   // source that was not served last wins. The pointer follows every grant.
   always_comb begin
      grant  = 2'b00;
      last_d = last_q;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == DEST_D1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end else begin
         grant = 2'b00;
      end
      if (grant[1]) begin
         last_d = DEST_D1;
      end else if (grant[0]) begin
         last_d = DEST_D0;
      end else begin
         last_d = last_q;
      end
   end

   // Last-served pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= DEST_D1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/egress_rr_arbiter.sv
// egress_rr_arbiter
//   Drains two destination FIFOs (D0, D1) into one registered output stream
//   using round-robin arbitration, with a consumer stall and per-destination
//   delivered-word counters.
//   Build option: define ARB_COUNTERS_EN to build the counters; otherwise
//   cnt_D0/cnt_D1 are tied to zero.
//   Ports:
//     clk, reset                - clock, synchronous active-high reset
//     D0_can_pop, D1_can_pop    - FIFO non-empty flags
//     D0_data_out, D1_data_out  - FIFO read data, valid the cycle after a pop
//     out_stall                 - consumer almost-full, blocks new pops
//     pop_D0, pop_D1            - combinational pop strobes (never both high)
//     data_out, valid_out, dest_out - registered merged word, 2 cycles after pop
//     cnt_D0, cnt_D1            - words delivered per destination (wrapping)
//     idle                      - no FIFO data and nothing in flight
module egress_rr_arbiter
   import egress_rr_arbiter_pkg::*;
#(
   parameter int BITNUMBER = 8,
   parameter int CNT_WIDTH = 8
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 D0_can_pop,
   input  logic                 D1_can_pop,
   input  logic [BITNUMBER-1:0] D0_data_out,
   input  logic [BITNUMBER-1:0] D1_data_out,
   input  logic                 out_stall,
   output logic                 pop_D0,
   output logic                 pop_D1,
   output logic [BITNUMBER-1:0] data_out,
   output logic                 valid_out,
   output logic                 dest_out,
   output logic [CNT_WIDTH-1:0] cnt_D0,
   output logic [CNT_WIDTH-1:0] cnt_D1,
   output logic                 idle
);

   logic [1:0]           grant;
   logic                 pop_any;
   arb_state_e           state_q, state_d;
   // Stage 1: word popped last cycle, FIFO read data present this cycle.
   logic                 s1_vld_q;
   logic                 s1_dst_q;
   // Stage 2: registered output word.
   logic                 out_vld_q;
   logic                 out_dst_q;
   logic [BITNUMBER-1:0] data_q, data_d;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .reset  (reset),
      .req    ({D1_can_pop, D0_can_pop}),
      .enable (!reset && !out_stall),
      .grant  (grant)
   );

   assign pop_D0  = grant[0];
   assign pop_D1  = grant[1];
   assign pop_any = grant[0] | grant[1];

   // Occupancy FSM: IDLE means both pipeline stages will be empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_any) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE, ST_DRAIN: begin
            if (pop_any) begin
               state_d = ST_ACTIVE;
            end else if (s1_vld_q) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the FIFO read data belonging to the stage-1 word.
   always_comb begin
      data_d = data_q;
      if (s1_vld_q) begin
         if (s1_dst_q == DEST_D1) begin
            data_d = D1_data_out;
         end else begin
            data_d = D0_data_out;
         end
      end else begin
         data_d = data_q;
      end
   end

   // FSM and merge pipeline registers; reset drops any in-flight word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         s1_vld_q  <= 1'b0;
         s1_dst_q  <= DEST_D0;
         out_vld_q <= 1'b0;
         out_dst_q <= DEST_D0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= pop_any;
         s1_dst_q  <= pop_D1 ? DEST_D1 : DEST_D0;
         out_vld_q <= s1_vld_q;
         data_q    <= data_d;
         if (s1_vld_q) begin
            out_dst_q <= s1_dst_q;
         end else begin
            out_dst_q <= out_dst_q;
         end
      end
   end

   assign data_out  = data_q;
   assign valid_out = out_vld_q;
   assign dest_out  = out_dst_q;
   // Reset forces idle even while a FIFO reports data.
   assign idle      = reset || ((state_q == ST_IDLE) && !D0_can_pop && !D1_can_pop);

`ifdef ARB_COUNTERS_EN
   logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

   // Delivered-word counters, bumped at the end of each valid output cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (out_vld_q) begin
         if (out_dst_q == DEST_D1) begin
            cnt1_q <= cnt1_q + CNT_WIDTH'(1);
         end else begin
            cnt0_q <= cnt0_q + CNT_WIDTH'(1);
         end
      end else begin
         cnt0_q <= cnt0_q;
         cnt1_q <= cnt1_q;
      end
   end

   assign cnt_D0 = cnt0_q;
   assign cnt_D1 = cnt1_q;
`else
   assign cnt_D0 = '0;
   assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// Self-checking bench for egress_rr_arbiter: a directed vector table, several
// hand-written sequences and randomized traffic against a queue-based model.
module tb_egress_rr_arbiter;
   import egress_rr_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset, D0_can_pop, D1_can_pop, out_stall;
   logic [7:0] D0_data_out, D1_data_out;
   logic       pop_D0, pop_D1, valid_out, dest_out, idle;
   logic [7:0] data_out, cnt_D0, cnt_D1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   egress_rr_arbiter #(.BITNUMBER(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .D0_can_pop(D0_can_pop), .D1_can_pop(D1_can_pop),
      .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
      .out_stall(out_stall),
      .pop_D0(pop_D0), .pop_D1(pop_D1),
      .data_out(data_out), .valid_out(valid_out), .dest_out(dest_out),
      .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .idle(idle)
   );

   // ---------------- reference model state ----------------
   typedef struct { logic [7:0] data; logic dest; int due; } word_t;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   word_t      pend[$];
   int         cyc = 0;
   logic       last_d1;      // 1: D1 was served last, so D0 wins a tie
   logic [7:0] cnt_m0, cnt_m1;

   typedef struct packed {
      logic can0, can1, stall, pop0, pop1, valid, dest, idle;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      last_d1 = 1'b1;
      cnt_m0  = 8'd0;
      cnt_m1  = 8'd0;
   endtask

   // One cycle, entered and left at the falling edge.
   task automatic run_cycle(input logic rst_v, input logic stall_v);
      logic       m0, m1;
      logic [7:0] w;
      reset      = rst_v;
      out_stall  = stall_v;
      D0_can_pop = (q0.size() != 0);
      D1_can_pop = (q1.size() != 0);
      #1;
      m0 = 1'b0;
      m1 = 1'b0;
      if (!rst_v && !stall_v) begin
         if (D0_can_pop && D1_can_pop) begin
            if (last_d1) m0 = 1'b1; else m1 = 1'b1;
         end else if (D0_can_pop) begin
            m0 = 1'b1;
         end else if (D1_can_pop) begin
            m1 = 1'b1;
         end
      end
      chk("pop_D0", pop_D0, m0);
      chk("pop_D1", pop_D1, m1);
      chk("idle", idle, rst_v || (!D0_can_pop && !D1_can_pop && pend.size() == 0));
      if (pend.size() != 0 && pend[0].due == cyc) begin
         chk("valid_out", valid_out, 1'b1);
         chk("data_out", data_out, pend[0].data);
         chk("dest_out", dest_out, pend[0].dest);
      end else begin
         chk("valid_out", valid_out, 1'b0);
      end
      chk("cnt_D0", cnt_D0, cnt_m0);
      chk("cnt_D1", cnt_D1, cnt_m1);
      if (pend.size() != 0 && pend[0].due == cyc) begin
`ifdef ARB_COUNTERS_EN
         if (pend[0].dest) cnt_m1 = cnt_m1 + 8'd1; else cnt_m0 = cnt_m0 + 8'd1;
`endif
         void'(pend.pop_front());
      end
      w = 8'd0;
      if (m0) begin
         w = q0.pop_front();
         pend.push_back('{data: w, dest: 1'b0, due: cyc + int'(POP_LATENCY)});
         last_d1 = 1'b0;
      end else if (m1) begin
         w = q1.pop_front();
         pend.push_back('{data: w, dest: 1'b1, due: cyc + int'(POP_LATENCY)});
         last_d1 = 1'b1;
      end
      if (rst_v) model_reset();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      // FIFO read data: popped word the next cycle, otherwise junk.
      D0_data_out = m0 ? w : 8'($urandom);
      D1_data_out = m1 ? w : 8'($urandom);
   endtask

   initial begin
      // can0 can1 stall | pop0 pop1 | valid dest | idle
      tbl[0]  = 8'b110_10_00_0;
      tbl[1]  = 8'b110_01_00_0;
      tbl[2]  = 8'b110_10_10_0;
      tbl[3]  = 8'b010_01_11_0;
      tbl[4]  = 8'b111_00_10_0;
      tbl[5]  = 8'b110_10_11_0;
      tbl[6]  = 8'b100_10_00_0;
      tbl[7]  = 8'b110_01_10_0;
      tbl[8]  = 8'b000_00_10_0;
      tbl[9]  = 8'b010_01_11_0;
      tbl[10] = 8'b110_10_00_0;
      tbl[11] = 8'b000_00_11_0;
      tbl[12] = 8'b000_00_10_0;
      tbl[13] = 8'b000_00_00_1;

      // Reset held two edges with D0 reporting data.
      reset = 1'b1; out_stall = 1'b0; D0_can_pop = 1'b1; D1_can_pop = 1'b0;
      D0_data_out = 8'hA0; D1_data_out = 8'h5B;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst pop_D0", pop_D0, 1'b0);
      chk("rst pop_D1", pop_D1, 1'b0);
      chk("rst valid_out", valid_out, 1'b0);
      chk("rst data_out", data_out, 8'h00);
      chk("rst dest_out", dest_out, 1'b0);
      chk("rst cnt_D0", cnt_D0, 8'h00);
      chk("rst cnt_D1", cnt_D1, 8'h00);
      chk("rst idle", idle, 1'b1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed vector table (fixed FIFO data A0 / 5B).
      for (int i = 0; i < 14; i++) begin
         D0_can_pop = tbl[i].can0;
         D1_can_pop = tbl[i].can1;
         out_stall  = tbl[i].stall;
         #1;
         chk($sformatf("tbl%0d pop_D0", i), pop_D0, tbl[i].pop0);
         chk($sformatf("tbl%0d pop_D1", i), pop_D1, tbl[i].pop1);
         chk($sformatf("tbl%0d valid", i), valid_out, tbl[i].valid);
         chk($sformatf("tbl%0d idle", i), idle, tbl[i].idle);
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d dest", i), dest_out, tbl[i].dest);
            chk($sformatf("tbl%0d data", i), data_out, tbl[i].dest ? 8'h5B : 8'hA0);
         end
         @(posedge clk);
         @(negedge clk);
      end

      // Model-checked sequences from here on.
      model_reset();
      run_cycle(1'b1, 1'b0);

      // Only D0 holds three words.
      q0 = '{8'h24, 8'h81, 8'h09};
      for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0);
`ifdef ARB_COUNTERS_EN
      chk("seq D0 x3 cnt_D0", cnt_D0, 8'd3);
`else
      chk("seq D0 x3 cnt_D0", cnt_D0, 8'd0);
`endif

      // Both FIFOs loaded right after reset: strict alternation D0 first.
      run_cycle(1'b1, 1'b0);
      q0 = '{8'h11, 8'h22};
      q1 = '{8'h33, 8'h44};
      for (int i = 0; i < 7; i++) run_cycle(1'b0, 1'b0);

      // Stall raised the cycle after a pop.
      q0 = '{8'hA1, 8'hA2, 8'hA3};
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b1);
      run_cycle(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

      // Reset one cycle after a pop drops the word.
      q0 = '{8'hC1, 8'hC2};
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

      // 257 D1 words: counter wraps.
      run_cycle(1'b1, 1'b0);
      for (int i = 0; i < 257; i++) q1.push_back(8'(i * 7 + 3));
      for (int i = 0; i < 262; i++) run_cycle(1'b0, 1'b0);
`ifdef ARB_COUNTERS_EN
      chk("wrap cnt_D1", cnt_D1, 8'd1);
`else
      chk("wrap cnt_D1", cnt_D1, 8'd0);
`endif

      // Randomized traffic, stalls and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 45 && q0.size() < 8) q0.push_back(8'($urandom));
         if ($urandom_range(0, 99) < 45 && q1.size() < 8) q1.push_back(8'($urandom));
         run_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25);
      end
      for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
